mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, downstream of the decode/execute pipeline latch.
- Consumes the latched operands (rdat1 → rs, rdat2 → rt) and op from the control unit.
- Computes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO registers.
- Raises busy so the hazard unit can freeze upstream latches until the result is ready.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  WIDTH  multiplicand / dividend.
- rt_val  in  WIDTH  multiplier / divisor.
- flush  in  1  abort the in-flight operation (branch/jump flush).
- wr_hi  in  1  MTHI write strobe.
- wr_lo  in  1  MTLO write strobe.
- wdat  in  WIDTH  MTHI/MTLO data.
- hi_o  out  WIDTH  HI register (MFHI source).
- lo_o  out  WIDTH  LO register (MFLO source).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when HI/LO have just been updated.

Behaviour:
- Interface: one clock, CLK; reset nRST is synchronous, active-low.
- Reset (nRST=0 at a rising edge): state=IDLE, hi_o=0, lo_o=0, busy=0, done=0, counter=0, internal operand registers cleared. Applies mid-operation; a partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE→RUN on start=1 and flush=0 (the accept edge, edge 0).
  - Latch op.
  - For signed ops, latch |rs| and |rt| plus both sign bits.
  - Clear the 2*WIDTH accumulator and counter.
- IDLE→DONE directly when start=1 with op DIV/DIVU and rt_val=0.
  - hi_o←rs_val, lo_o←all ones.
  - Written at the accept edge.
- RUN: one iteration per edge; counter increments.
  - Multiply: shift-add. If the multiplier LSB=1, add the multiplicand to the upper half; shift the accumulator and multiplier right 1.
  - Divide: restoring. Shift the remainder/quotient pair left 1; if the remainder ≥ divisor, subtract and set the quotient LSB.
- RUN→DONE at the edge completing iteration WIDTH (counter==WIDTH-1).
  - hi_o/lo_o are written at that same edge with the sign-corrected result.
  - Latency: accept at edge 0 → busy cycles 1..32 → done=1 in cycle 33 → result visible on hi_o/lo_o from cycle 33.
- DONE→IDLE unconditionally next edge. done=1 only in DONE; busy=1 in RUN and DONE.
- Result mapping:
  - Multiply: hi_o = product[63:32], lo_o = product[31:0].
  - Divide: lo_o = quotient, hi_o = remainder.
- Sign rules:
  - Signed product is negated if the sign bits differ.
  - Signed quotient is negated if the sign bits differ.
  - Signed remainder takes the dividend's sign.
  - 0x80000000 / -1 (DIV) → lo_o=0x80000000, hi_o=0; no trap.
- start while busy=1: ignored; the hazard unit is responsible for holding the request.
- flush=1 in RUN or DONE: next state IDLE; hi_o/lo_o retain their pre-operation values. If flush coincides with the RUN→DONE edge, flush wins and no write occurs.
- flush=1 in IDLE blocks acceptance of start.
- wr_hi/wr_lo:
  - Honoured only when state=IDLE and start=0; write the wdat value at the edge.
  - Ignored when busy=1, or when start is accepted in the same cycle (start wins).
  - Both strobes together write both registers.
- Reads: hi_o/lo_o are plain register outputs with no bypass; a same-cycle MTHI is visible next cycle.

Optional Feature:
- Macro MULT_DIV_EARLY_OUT_EN.
- Defined: for MULT/MULTU, after each RUN iteration, if the remaining shifted multiplier == 0, the next state is DONE and the accumulator is aligned by the remaining shift count. The result is identical to full iteration.
  - Multiplier 0 → done in cycle 2.
  - Multiplier 3 → done in cycle 3.
  - Divide latency is unchanged.
- Undefined: fixed WIDTH-iteration latency for all ops (done in cycle 33).

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0x00000002, start at cycle 0 → busy cycles 1..32, done cycle 33, hi_o=0x00000001, lo_o=0xFFFFFFFE.
- MULT rs=0xFFFFFFFD (-3) rt=0x00000007 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB. DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- DIV rs=0xFFFFFFF9 (-7) rt=2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU rs=100 rt=7 → lo_o=14, hi_o=2.
- DIVU rs=0x00001234 rt=0 → done cycle 1, busy cycle 1 only, hi_o=0x00001234, lo_o=0xFFFFFFFF.
- Preload via wr_hi/wr_lo wdat=0xAAAA5555, start MULTU, flush in cycle 10, start re-pulsed in cycle 5 → busy low from cycle 11, no done pulse, hi_o=lo_o=0xAAAA5555. Also check wr_hi asserted in cycle 5 is ignored.
- nRST=0 in cycle 15 of a DIVU → next cycle busy=0, done=0, hi_o=lo_o=0. With MULT_DIV_EARLY_OUT_EN defined: MULTU 5×3 → done cycle 3, lo_o=15, hi_o=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit for the execute stage.
// Produces the architectural HI/LO registers and holds busy high while an
// operation is in flight so upstream latches can be frozen.
//
// Ports:
//   CLK            rising-edge clock
//   nRST           synchronous active-low reset
//   start, op      request (sampled in IDLE); op 00 MULT 01 MULTU 10 DIV 11 DIVU
//   rs_val, rt_val multiplicand/dividend, multiplier/divisor
//   flush          abort in-flight operation; blocks acceptance in IDLE
//   wr_hi, wr_lo   MTHI/MTLO strobes (IDLE and start=0 only), data on wdat
//   hi_o, lo_o     HI/LO registers
//   busy           state != IDLE
//   done           one-cycle pulse when HI/LO have just been updated
//
// Optional build macro: MULT_DIV_EARLY_OUT_EN
//   When defined, a multiply finishes as soon as the remaining multiplier
//   bits are all zero; the accumulator is realigned so the result matches a
//   full-length run. Divide latency is unaffected.
//
// Handshake: start is a level request looked at only while busy=0; once
// accepted the caller must hold its inputs off until done (or flush).
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdat,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;     // |multiplicand|, or |dividend| shifted out MSB-first
    logic [WIDTH-1:0]   r_b;     // |multiplier| shifted right, or |divisor|
    logic               r_sa;    // rs sign (signed ops only)
    logic               r_sb;    // rt sign (signed ops only)
    logic [2*WIDTH-1:0] r_acc;   // mul: product; div: {remainder, quotient}
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    // Operand conditioning at acceptance
    logic               w_signed;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_abs;
    logic [WIDTH-1:0]   w_rt_abs;

    assign w_signed = ~op[0];
    assign w_rs_neg = w_signed & rs_val[WIDTH-1];
    assign w_rt_neg = w_signed & rt_val[WIDTH-1];
    assign w_rs_abs = w_rs_neg ? (~rs_val + 1'b1) : rs_val;
    assign w_rt_abs = w_rt_neg ? (~rt_val + 1'b1) : rt_val;

    // One iteration of each algorithm
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0]   w_mul_b;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_last;
    logic               w_finish;
    logic [2*WIDTH-1:0] w_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    always_comb begin
        // Shift-add: the add can carry out of the upper half, so keep WIDTH+1 bits
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
        w_mul_acc = {w_sum, r_acc[WIDTH-1:1]};
        w_mul_b   = r_b >> 1;

        // Restoring divide: remainder < divisor, so the difference always fits WIDTH bits
        w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
        w_ge      = (w_trial >= {1'b0, r_b});
        w_rem_nxt = w_ge ? (w_trial[WIDTH-1:0] - r_b) : w_trial[WIDTH-1:0];
        w_div_acc = {w_rem_nxt, r_acc[WIDTH-2:0], w_ge};

        w_acc_nxt = r_op[1] ? w_div_acc : w_mul_acc;
        w_last    = (r_cnt == CNT_W'(WIDTH - 1));
`ifdef MULT_DIV_EARLY_OUT_EN
        w_finish  = w_last | (~r_op[1] & (w_mul_b == '0));
        // Skipped iterations would only have shifted the product right
        w_mag     = w_acc_nxt >> (CNT_W'(WIDTH - 1) - r_cnt);
`else
        w_finish  = w_last;
        w_mag     = w_acc_nxt;
`endif
        w_prod    = (r_sa ^ r_sb) ? (~w_mag + 1'b1) : w_mag;
        w_quo     = (r_sa ^ r_sb) ? (~w_mag[WIDTH-1:0] + 1'b1) : w_mag[WIDTH-1:0];
        w_rem     = r_sa ? (~w_mag[2*WIDTH-1:WIDTH] + 1'b1) : w_mag[2*WIDTH-1:WIDTH];
        w_res_hi  = r_op[1] ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        w_res_lo  = r_op[1] ? w_quo : w_prod[WIDTH-1:0];
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !flush) begin
                        r_op   <= op;
                        r_a    <= w_rs_abs;
                        r_b    <= w_rt_abs;
                        r_sa   <= w_rs_neg;
                        r_sb   <= w_rt_neg;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (op[1] && (rt_val == '0)) begin
                            // Divide by zero: fixed result, no iterations
                            r_hi    <= rs_val;
                            r_lo    <= '1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else if (!start) begin
                        if (wr_hi) r_hi <= wdat;
                        if (wr_lo) r_lo <= wdat;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_op[1]) r_a <= r_a << 1;
                        else         r_b <= w_mul_b;
                        if (w_finish) begin
                            r_hi    <= w_res_hi;
                            r_lo    <= w_res_lo;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_mult_div_unit;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdat;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdat(wdat),
        .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .done(done)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference model: plain 64-bit arithmetic
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = '0;
        l = '0;
        if (o[1] && b == 32'd0) begin
            h = a;
            l = 32'hFFFFFFFF;
        end else begin
            case (o)
                2'b00: begin p = sa * sb; up = p; h = up[63:32]; l = up[31:0]; end
                2'b01: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
                2'b10: begin q = sa / sb; r = sa % sb; up = q; l = up[31:0]; up = r; h = up[31:0]; end
                default: begin l = a / b; h = a % b; end
            endcase
        end
    endfunction

    // cycle (counted from the accept edge) in which done is expected
    function automatic int exp_done_cycle(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int iters;
        if (o[1] && b == 32'd0) return 1;
        m = (!o[0] && b[31]) ? (~b + 1) : b;
        iters = 32;
`ifdef MULT_DIV_EARLY_OUT_EN
        if (!o[1]) begin
            iters = 1;
            for (int i = 0; i < 32; i++) if (m[i]) iters = i + 1;
        end
`endif
        return iters + 1;
    endfunction

    // driver: issue one operation in the current cycle (cycle 0), follow it to completion
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int exp_cyc, cyc;
        logic busy_ok;
        model(o, a, b, eh, el);
        exp_cyc = exp_done_cycle(o, b);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        tick();
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        check($sformatf("done_cycle op%0d %h/%h", o, a, b), cyc, exp_cyc);
        check("busy_before_done", busy_ok, 1'b1);
        check("busy_in_done", busy, 1'b1);
        check($sformatf("hi op%0d %h,%h", o, a, b), hi_o, eh);
        check($sformatf("lo op%0d %h,%h", o, a, b), lo_o, el);
        tick();
        check("done_pulse_end", done, 1'b0);
        check("busy_end", busy, 1'b0);
    endtask

    task automatic write_hilo(input logic h, input logic l, input logic [31:0] d);
        wr_hi = h; wr_lo = l; wdat = d;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
    endtask

    initial begin : stim
        logic saw_done;
        logic [1:0] ro;
        logic [31:0] ra, rb;
        nRST = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdat = '0;
        tick();
        tick();
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        nRST = 1'b1;
        tick();

        // directed operations
        run_op(2'b01, 32'hFFFFFFFF, 32'h00000002);
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b11, 32'h00001234, 32'd0);
        run_op(2'b00, 32'h80000000, 32'h80000000);
        run_op(2'b01, 32'd12345, 32'd0);
`ifdef MULT_DIV_EARLY_OUT_EN
        run_op(2'b01, 32'd5, 32'd3);
`endif

        // MTHI/MTLO writes
        write_hilo(1'b1, 1'b1, 32'hAAAA5555);
        check("mt_both_hi", hi_o, 32'hAAAA5555);
        check("mt_both_lo", lo_o, 32'hAAAA5555);

        // flush in cycle 10 with a re-pulsed start and ignored MTHI in cycle 5
        saw_done = 1'b0;
        start = 1'b1; op = 2'b01; rs_val = $urandom; rt_val = $urandom | 32'h80000000;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        start = 1'b1; op = 2'b11; rt_val = 32'd0; wr_hi = 1'b1; wdat = 32'h12345678;
        if (done === 1'b1) saw_done = 1'b1;
        tick();
        start = 1'b0; wr_hi = 1'b0;
        check("mthi_while_busy", hi_o, 32'hAAAA5555);
        for (int c = 6; c < 10; c++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        flush = 1'b1;
        if (done === 1'b1) saw_done = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_done", done, 1'b0);
        check("flush_no_done_pulse", saw_done, 1'b0);
        check("flush_hi", hi_o, 32'hAAAA5555);
        check("flush_lo", lo_o, 32'hAAAA5555);

        // flush coinciding with the final iteration edge: no write
        write_hilo(1'b1, 1'b0, 32'h13579BDF);
        write_hilo(1'b0, 1'b1, 32'h2468ACE0);
        check("mtlo_only_hi", hi_o, 32'h13579BDF);
        check("mtlo_only_lo", lo_o, 32'h2468ACE0);
        start = 1'b1; op = 2'b01; rs_val = 32'd9; rt_val = 32'h80000001;
        tick();
        start = 1'b0;
        for (int c = 1; c < 32; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("lastflush_done", done, 1'b0);
        check("lastflush_busy", busy, 1'b0);
        check("lastflush_hi", hi_o, 32'h13579BDF);
        check("lastflush_lo", lo_o, 32'h2468ACE0);

        // flush in IDLE blocks start (and MTHI with start=1)
        start = 1'b1; flush = 1'b1; op = 2'b11; rs_val = 32'd1; rt_val = 32'd0;
        wr_hi = 1'b1; wdat = 32'h0BADF00D;
        tick();
        start = 1'b0; flush = 1'b0; wr_hi = 1'b0;
        check("idle_flush_busy", busy, 1'b0);
        check("idle_flush_hi", hi_o, 32'h13579BDF);

        // reset in cycle 15 of a DIVU
        start = 1'b1; op = 2'b11; rs_val = 32'hDEADBEEF; rt_val = 32'd3;
        tick();
        start = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_hi", hi_o, 32'd0);
        check("midrst_lo", lo_o, 32'd0);
        tick();

        // randomized operations
        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(0, 15);
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
            run_op(ro, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
